// File: rtl/face_filter_pkg.sv
// -----------------------------------------------------------------------------
// face_filter_pkg
//   Shared definitions for the line-RAM feeder, the line RAM and the reader
//   stage.
//   - wr_state_t : writer FSM state encoding (IDLE / FILL / FULL)
//   - FF_BAND    : RAM word width in bits
//   - FF_DEPTH   : RAM depth in words
//   - FF_PIX_W   : pixel width in bits
// -----------------------------------------------------------------------------
package face_filter_pkg;

    localparam int FF_BAND  = 64;
    localparam int FF_DEPTH = 128;
    localparam int FF_PIX_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } wr_state_t;

    // Pixels per RAM word for a given word/pixel width pair.
    function automatic int pix_per_word(input int band, input int pix_w);
        return band / pix_w;
    endfunction

endpackage

// File: rtl/pixel_lane_packer.sv
// -----------------------------------------------------------------------------
// pixel_lane_packer
//   Packs PIX_W-bit pixels into a BAND-bit word, lane 0 in the LSBs. Owns the
//   lane counter and the partial-word register.
//
// Ports
//   clk       in   1      clock, posedge
//   rst       in   1      synchronous active-high reset, drops any partial word
//   accept    in   1      pixel is taken into the word this cycle
//   sof       in   1      accepted pixel starts a frame: discard partial word,
//                         pixel lands in lane 0
//   eol       in   1      accepted pixel ends a line: word completes now
//   data      in   PIX_W  pixel value
//   word_done out  1      combinational: this accept completes a word
//   word      out  BAND   combinational: completed word (valid with word_done),
//                         unfilled lanes are zero
// -----------------------------------------------------------------------------
module pixel_lane_packer
    import face_filter_pkg::*;
#(
    parameter int BAND  = FF_BAND,
    parameter int PIX_W = FF_PIX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             accept,
    input  logic             sof,
    input  logic             eol,
    input  logic [PIX_W-1:0] data,
    output logic             word_done,
    output logic [BAND-1:0]  word
);

    localparam int PPW    = pix_per_word(BAND, PIX_W);
    localparam int LANE_W = (PPW > 1) ? $clog2(PPW) : 1;

    logic [LANE_W-1:0] lane_q;
    logic [LANE_W-1:0] lane_eff;
    logic [BAND-1:0]   word_q;
    logic [BAND-1:0]   word_next;

    // A start-of-frame pixel behaves as if the packer were empty, so the
    // partial word simply vanishes without ever reaching the RAM.
    always_comb begin
        lane_eff  = sof ? '0 : lane_q;
        word_next = sof ? '0 : word_q;
        word_next[int'(lane_eff) * PIX_W +: PIX_W] = data;
        word_done = accept && (eol || (lane_eff == LANE_W'(PPW - 1)));
    end

    assign word = word_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q <= '0;
            word_q <= '0;
        end else if (accept) begin
            if (word_done) begin
                // Clearing here keeps unfilled lanes of the next word at zero.
                lane_q <= '0;
                word_q <= '0;
            end else begin
                lane_q <= lane_eff + 1'b1;
                word_q <= word_next;
            end
        end
    end

endmodule

// File: rtl/ram_line_writer.sv
// -----------------------------------------------------------------------------
// ram_line_writer
//   Upstream feeder for the line RAM. Accepts a pixel stream, packs pixels into
//   RAM words (pixel_lane_packer) and drives the RAM write port one word per
//   write. Frames start on pix_sof; pix_eol flushes a partial word. Without
//   OVERWRITE_EN the stream stalls once DEPTH words are written, until
//   buf_release. With OVERWRITE_EN defined the address wraps and writing never
//   stops.
//
// Configuration macro: OVERWRITE_EN
//
// Ports
//   clk            in   1         clock, posedge
//   rst            in   1         synchronous active-high reset
//   pix_valid      in   1         pixel present
//   pix_ready      out  1         block accepts pixel
//   pix_data       in   PIX_W     pixel value
//   pix_sof        in   1         first pixel of frame
//   pix_eol        in   1         last pixel of line
//   buf_release    in   1         consumer done with buffer (1-cycle pulse)
//   ram_wr         out  1         RAM write strobe, one cycle per word
//   ram_addr       out  ADDR_W    RAM word address
//   ram_data       out  BAND      packed word (holds last written value)
//   buf_full       out  1         buffer full (stall) / wrap pulse (overwrite)
//   words_written  out  ADDR_W+1  words written this frame
//   state_dbg      out  2         current FSM state (wr_state_t encoding)
//
// Handshake: a pixel transfers on a posedge where pix_valid and pix_ready are
// both high. pix_ready depends only on the FSM state, never on pix_valid;
// upstream keeps pix_valid and its payload stable while pix_ready is low.
// -----------------------------------------------------------------------------
module ram_line_writer
    import face_filter_pkg::*;
#(
    parameter  int BAND   = FF_BAND,
    parameter  int DEPTH  = FF_DEPTH,
    parameter  int PIX_W  = FF_PIX_W,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [PIX_W-1:0]  pix_data,
    input  logic              pix_sof,
    input  logic              pix_eol,
    input  logic              buf_release,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [BAND-1:0]   ram_data,
    output logic              buf_full,
    output logic [ADDR_W:0]   words_written,
    output logic [1:0]        state_dbg
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    wr_state_t         state_q;
    wr_state_t         state_d;

    logic              xfer;
    logic              pack_accept;
    logic              sof_acc;
    logic              word_done;
    logic [BAND-1:0]   word;

    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] addr_eff;
    logic [ADDR_W:0]   ww_q;
    logic [ADDR_W:0]   ww_eff;
    logic              last_word;

`ifdef OVERWRITE_EN
    logic              wrap_q;
`endif

    // ------------------------------------------------------------------
    // Datapath qualifiers
    // ------------------------------------------------------------------
    assign xfer        = pix_valid && pix_ready;
    // In IDLE only a start-of-frame pixel is packed; others are taken and
    // dropped so upstream never blocks between frames.
    assign pack_accept = xfer && ((state_q == FILL) || pix_sof);
    assign sof_acc     = pack_accept && pix_sof;

    // A start-of-frame pixel restarts addressing and counting on the same edge
    // it is written, so sof+eol lands at address 0.
    assign addr_eff  = sof_acc ? '0 : ptr_q;
    assign ww_eff    = sof_acc ? '0 : ww_q;
    assign last_word = word_done && (addr_eff == LAST_ADDR);

    pixel_lane_packer #(
        .BAND  (BAND),
        .PIX_W (PIX_W)
    ) u_packer (
        .clk       (clk),
        .rst       (rst),
        .accept    (pack_accept),
        .sof       (sof_acc),
        .eol       (pix_eol),
        .data      (pix_data),
        .word_done (word_done),
        .word      (word)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (sof_acc) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                state_d = FILL;
            end
            FULL: begin
`ifndef OVERWRITE_EN
                if (buf_release) begin
                    state_d = IDLE;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
`ifndef OVERWRITE_EN
        // Going FULL on the completing edge drops pix_ready in the same cycle
        // the last word is on the RAM port, so no pixel slips past the stall.
        if (last_word) begin
            state_d = FULL;
        end
`endif
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
`ifdef OVERWRITE_EN
        pix_ready = 1'b1;
        buf_full  = wrap_q;
`else
        pix_ready = (state_q != FULL);
        buf_full  = (state_q == FULL);
`endif
    end

    assign state_dbg = state_q;

    // ------------------------------------------------------------------
    // Pointer, word count and registered RAM write port
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q    <= '0;
            ww_q     <= '0;
            ram_wr   <= 1'b0;
            ram_addr <= '0;
            ram_data <= '0;
        end else begin
            ram_wr <= word_done;
            if (word_done) begin
                ram_addr <= addr_eff;
                ram_data <= word;
                ptr_q    <= last_word ? '0 : addr_eff + 1'b1;
`ifdef OVERWRITE_EN
                ww_q     <= (ww_eff == DEPTH_CNT) ? ww_eff : ww_eff + 1'b1;
`else
                ww_q     <= ww_eff + 1'b1;
`endif
            end else if (sof_acc) begin
                ptr_q <= '0;
                ww_q  <= '0;
            end
`ifndef OVERWRITE_EN
            else if ((state_q == FULL) && buf_release) begin
                ptr_q <= '0;
                ww_q  <= '0;
            end
`endif
        end
    end

`ifdef OVERWRITE_EN
    // One-cycle flag aligned with the write that wraps the address.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= last_word;
        end
    end
`endif

    assign words_written = ww_q;

endmodule
